// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Issue/completion controller for the RV32M iterative divider.
//            Handles divide corner cases locally, reuses the last result, and
//            returns a tagged result to writeback with valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module div_ctrl #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,

    input  logic             flush,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag,

    output logic             div_start,
    output logic             div_dividend_signed,
    output logic             div_divisor_signed,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    input  logic             div_valid,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder,
    input  logic             div_div_by_zero
);

    localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic            r_op_rem;
    logic            w_accept;
    logic            w_req_signed;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_hit;
    logic            w_fast;
    logic            w_div_done;
    logic [XLEN-1:0] w_fast_data;

    logic            r_c_valid;
    logic            r_c_signed;
    logic [XLEN-1:0] r_c_rs1;
    logic [XLEN-1:0] r_c_rs2;
    logic [XLEN-1:0] r_c_quo;
    logic [XLEN-1:0] r_c_rem;

    // Zero divisors are resolved here, so the divider's own flag is never needed.
    logic w_unused;
    assign w_unused = div_div_by_zero;

    // ------------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------------
    assign w_accept     = req_valid && req_ready;
    assign w_req_signed = !req_op[0];
    assign w_div_zero   = (req_rs2 == '0);
    assign w_ovf        = w_req_signed && (req_rs1 == c_MIN_NEG) && (req_rs2 == '1);
    assign w_hit        = r_c_valid
                          && (req_rs1 == r_c_rs1)
                          && (req_rs2 == r_c_rs2)
                          && (w_req_signed == r_c_signed);
    assign w_fast       = w_div_zero || w_ovf || w_hit;
    assign w_div_done   = (r_state == S_WAIT) && div_valid && !flush;

    always_comb begin
        w_fast_data = '0;
        if (w_div_zero) begin
            w_fast_data = req_op[1] ? req_rs1 : '1;
        end else if (w_ovf) begin
            w_fast_data = req_op[1] ? '0 : c_MIN_NEG;
        end else if (w_hit) begin
            w_fast_data = req_op[1] ? r_c_rem : r_c_quo;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        res_valid    = 1'b0;
        div_start    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is accepted early.
                req_ready = !flush && !rst;
                if (w_accept) begin
                    w_next_state = w_fast ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else begin
                    div_start    = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // The divider cannot be aborted once started: drain it unless it
                // is completing in this very cycle.
                if (flush) begin
                    w_next_state = div_valid ? S_IDLE : S_DRAIN;
                end else if (div_valid) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                res_valid = !flush;
                if (flush || res_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand / result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_rem            <= 1'b0;
            res_data            <= '0;
            res_tag             <= '0;
            div_dividend        <= '0;
            div_divisor         <= '0;
            div_dividend_signed <= 1'b0;
            div_divisor_signed  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_rem            <= req_op[1];
                res_tag             <= req_tag;
                div_dividend        <= req_rs1;
                div_divisor         <= req_rs2;
                div_dividend_signed <= w_req_signed;
                div_divisor_signed  <= w_req_signed;
                if (w_fast) begin
                    res_data <= w_fast_data;
                end
            end
            if (w_div_done) begin
                res_data <= r_op_rem ? div_remainder : div_quotient;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Last-result cache; divider operands are still held when div_valid fires.
    // ------------------------------------------------------------------------
    generate
        if (REUSE_EN) begin : g_cache
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_c_valid  <= 1'b0;
                    r_c_signed <= 1'b0;
                    r_c_rs1    <= '0;
                    r_c_rs2    <= '0;
                    r_c_quo    <= '0;
                    r_c_rem    <= '0;
                end else if (flush) begin
                    r_c_valid <= 1'b0;
                end else if (w_div_done) begin
                    r_c_valid  <= 1'b1;
                    r_c_signed <= div_dividend_signed;
                    r_c_rs1    <= div_dividend;
                    r_c_rs2    <= div_divisor;
                    r_c_quo    <= div_quotient;
                    r_c_rem    <= div_remainder;
                end
            end
        end else begin : g_no_cache
            assign r_c_valid  = 1'b0;
            assign r_c_signed = 1'b0;
            assign r_c_rs1    = '0;
            assign r_c_rs2    = '0;
            assign r_c_quo    = '0;
            assign r_c_rem    = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// tb_div_ctrl: directed and randomized checks of div_ctrl against a
// behavioural RV32M divide model, with the bench acting as the divider.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_tag;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_tag;
    logic        div_start;
    logic        div_dividend_signed;
    logic        div_divisor_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_valid;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_div_by_zero;

    int checks = 0;
    int errors = 0;

    // Model of the controller's reuse cache
    logic        mc_valid = 1'b0;
    logic [31:0] mc_a;
    logic [31:0] mc_b;
    logic        mc_s;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_rs1             (req_rs1),
        .req_rs2             (req_rs2),
        .req_tag             (req_tag),
        .flush               (flush),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_data            (res_data),
        .res_tag             (res_tag),
        .div_start           (div_start),
        .div_dividend_signed (div_dividend_signed),
        .div_divisor_signed  (div_divisor_signed),
        .div_dividend        (div_dividend),
        .div_divisor         (div_divisor),
        .div_valid           (div_valid),
        .div_quotient        (div_quotient),
        .div_remainder       (div_remainder),
        .div_div_by_zero     (div_div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    // Divider response {quotient, remainder}; only used for legal operands
    function automatic logic [63:0] hw_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (s) return {32'(sa / sb), 32'(sa % sb)};
        return {a / b, a % b};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_tag"}, res_tag, 0);
        chk({tag, "_div_start"}, div_start, 0);
        chk({tag, "_dividend"}, div_dividend, 0);
        chk({tag, "_divisor"}, div_divisor, 0);
        chk({tag, "_dividend_signed"}, div_dividend_signed, 0);
        chk({tag, "_divisor_signed"}, div_divisor_signed, 0);
    endtask

    // Present a request at a negedge; returns at the negedge of the cycle after accept.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        req_tag   = 5'($urandom);
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int lat, input int bp,
                         input logic [31:0] exp);
        logic s;
        logic launch;
        s      = !op[0];
        launch = (b != 32'd0) && !(s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                 && !(mc_valid && mc_a == a && mc_b == b && mc_s == s);
        issue(op, a, b, tag);
        chk("div_start", div_start, launch);
        if (launch) begin
            chk("dividend", div_dividend, a);
            chk("divisor", div_divisor, b);
            chk("dividend_signed", div_dividend_signed, s);
            chk("divisor_signed", div_divisor_signed, s);
            chk("res_valid_launch", res_valid, 0);
            for (int i = 0; i <= lat; i++) begin
                @(negedge clk);
                chk("div_start_wait", div_start, 0);
                chk("dividend_hold", div_dividend, a);
                chk("divisor_hold", div_divisor, b);
                chk("res_valid_wait", res_valid, 0);
            end
            div_valid = 1'b1;
            {div_quotient, div_remainder} = hw_div(a, b, s);
            @(negedge clk);
            div_valid     = 1'b0;
            div_quotient  = $urandom;
            div_remainder = $urandom;
            mc_valid = 1'b1;
            mc_a     = a;
            mc_b     = b;
            mc_s     = s;
        end
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp);
        chk("res_tag", res_tag, tag);
        chk("div_start_resp", div_start, 0);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, exp);
            chk("bp_res_tag", res_tag, tag);
            chk("bp_req_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_after", res_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] last_a;
        logic [31:0] last_b;

        rst             = 1'b1;
        req_valid       = 1'b0;
        req_op          = 2'b00;
        req_rs1         = '0;
        req_rs2         = '0;
        req_tag         = '0;
        flush           = 1'b0;
        res_ready       = 1'b0;
        div_valid       = 1'b0;
        div_quotient    = '0;
        div_remainder   = '0;
        div_div_by_zero = 1'b0;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_post_reset", req_ready, 1);

        // Unsigned with reuse
        do_op(2'b01, 32'd100, 32'd7, 5'd3, 3, 0, 32'd14);
        do_op(2'b11, 32'd100, 32'd7, 5'd4, 0, 0, 32'd2);
        // Signed
        do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd5, 2, 0, 32'hFFFF_FFF2);
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd6, 2, 0, 32'hFFFF_FFFE);
        // Divide by zero
        do_op(2'b00, 32'd5, 32'd0, 5'd8, 0, 0, 32'hFFFF_FFFF);
        do_op(2'b11, 32'd5, 32'd0, 5'd9, 0, 0, 32'd5);
        // Signed overflow, then the unsigned form goes to the divider
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 0, 32'h8000_0000);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0, 32'd0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 0, 32'd0);
        // Backpressure
        do_op(2'b01, 32'd200, 32'd3, 5'd13, 2, 10, 32'd66);

        // Flush in WAIT drains the divider and clears the cache
        do_op(2'b00, 32'd1000, 32'd9, 5'd14, 1, 0, 32'd111);
        issue(2'b01, 32'd77, 32'd5, 5'd15);
        chk("flush_wait_start", div_start, 1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_wait_req_ready", req_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        mc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_res_valid", res_valid, 0);
            chk("drain_req_ready", req_ready, 0);
            @(negedge clk);
        end
        div_valid     = 1'b1;
        div_quotient  = 32'd15;
        div_remainder = 32'd2;
        @(negedge clk);
        div_valid = 1'b0;
        chk("drain_done_res_valid", res_valid, 0);
        chk("drain_done_req_ready", req_ready, 1);
        do_op(2'b10, 32'd1000, 32'd9, 5'd16, 1, 0, 32'd1);

        // Flush in LAUNCH suppresses the start pulse
        issue(2'b00, 32'd50, 32'd3, 5'd17);
        flush = 1'b1;
        #1;
        chk("flush_launch_div_start", div_start, 0);
        @(negedge clk);
        mc_valid = 1'b0;
        chk("flush_launch_res_valid", res_valid, 0);
        chk("flush_launch_div_start2", div_start, 0);
        chk("flush_idle_req_ready", req_ready, 0);
        flush = 1'b0;
        #1;
        chk("flush_launch_req_ready", req_ready, 1);
        @(negedge clk);

        // Flush in RESP drops the result
        issue(2'b00, 32'd5, 32'd0, 5'd18);
        chk("flush_resp_valid_pre", res_valid, 1);
        flush = 1'b1;
        #1;
        chk("flush_resp_res_valid", res_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_resp_req_ready", req_ready, 1);
        chk("flush_resp_res_valid2", res_valid, 0);
        @(negedge clk);

        // Reset in WAIT
        do_op(2'b10, 32'd1000, 32'd9, 5'd19, 0, 0, 32'd1);
        issue(2'b01, 32'd1234, 32'd10, 5'd20);
        chk("rst_wait_start", div_start, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_wait");
        @(negedge clk);
        rst      = 1'b0;
        mc_valid = 1'b0;
        @(negedge clk);
        chk("rst_wait_req_ready", req_ready, 1);
        do_op(2'b00, 32'd1000, 32'd9, 5'd21, 1, 0, 32'd111);

        // Randomized traffic
        last_a = 32'd1000;
        last_b = 32'd9;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a = last_a;
                b = last_b;
            end else begin
                a = pick();
                b = pick();
            end
            do_op(op, a, b, 5'($urandom), $urandom_range(0, 4), $urandom_range(0, 2),
                  ref_result(op, a, b));
            last_a = a;
            last_b = b;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
